adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
Shares the single 32-bit combinational adder among NUM_REQ requesters, e.g. PC+4 increment, branch-target computation and the address-offset unit. It runs a round-robin request/grant/done handshake, registers the winner's operands onto the adder inputs and captures the adder output one cycle later. One addition is in flight at a time. The adder stays a separate instance; this block drives its add_in1/add_in2 and reads its add_out.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATA_W, 32, operand/result width; must match the adder

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request; held until that requester's done
op_a  input  NUM_REQ*DATA_W  flattened operand A; slice i belongs to requester i
op_b  input  NUM_REQ*DATA_W  flattened operand B; slice i belongs to requester i
gnt  output  NUM_REQ  one-hot, registered; high during EXEC for the winner
done  output  NUM_REQ  one-hot, registered; one-cycle pulse in RESP
result  output  DATA_W  registered sum; valid while done != 0, held afterwards
ovf  output  1  registered signed-overflow flag qualified with done
add_in1  output  DATA_W  registered operand A to the adder
add_in2  output  DATA_W  registered operand B to the adder
add_out  input  DATA_W  adder sum (combinational from add_in1/add_in2)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, ptr=0.
  - gnt=0, done=0, result=0, ovf=0, add_in1=0, add_in2=0.
  - Any in-flight operation is abandoned; no done pulse is produced for it.
- States: IDLE -> EXEC -> RESP -> IDLE. RESP always returns to IDLE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w = first set req bit scanning ptr, ptr+1, ... with wrap modulo NUM_REQ.
  - At the edge: add_in1<=op_a[w], add_in2<=op_b[w], gnt<=onehot(w), latch w, go to EXEC.
- EXEC:
  - Adder settles combinationally.
  - At the edge: result<=add_out, ovf<=(add_in1[MSB]==add_in2[MSB]) && (add_out[MSB]!=add_in1[MSB]).
  - Same edge: done<=onehot(w), gnt<=0, ptr<=(w+1) mod NUM_REQ, go to RESP.
- RESP:
  - done is high for exactly this cycle; req is ignored.
  - At the edge: done<=0, go to IDLE.
  - result and ovf hold until the next capture.
- Latency: req sampled high in IDLE at edge k -> gnt high in cycle k+1 -> done and result valid in cycle k+2.
- Throughput: one addition per 3 cycles.
- Handshake:
  - A requester must deassert req by the edge that ends its done cycle unless it wants another operation.
  - A req still high in IDLE is treated as a new request.
- Operands are sampled only at the IDLE->EXEC edge. Later changes to op_a/op_b, including during EXEC, do not affect the result.
- If req drops during EXEC, the operation still completes and done still pulses.
- Arithmetic: modulo 2^DATA_W; carry-out is discarded; ovf is the two's-complement overflow.
- Simultaneous requests: round-robin from ptr, so every continuously requesting requester is served within NUM_REQ operations (no starvation).
- Outputs are never X after reset. gnt and done are never both nonzero in the same cycle.

Decomposition:
- Shared package:
  - State encoding constants: ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
  - DATA_W default 32.
  - onehot/index width helper constant: IDX_W = clog2(NUM_REQ).
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req, ptr.
  - Outputs: any, winner index.

Test Plan:
- Single request, sum: after reset, req=3'b001, op_a[0]=5, op_b[0]=12 -> gnt=001 next cycle, then done=001 with result=17, ovf=0; add_in1=5, add_in2=12 during EXEC.
- Fairness: req=3'b111 held continuously with distinct operands -> done order 001, 010, 100, 001; each done exactly 3 cycles apart; gnt one-hot.
- Signed overflow: op_a=32'h7FFFFFFF, op_b=1 -> result=32'h80000000, ovf=1.
- Unsigned wrap: op_a=32'hFFFFFFFF, op_b=1 -> result=0, ovf=0.
- Operand change after grant: op_a changed from 5 to 100 during EXEC -> result=17. Also drop req during EXEC -> done still pulses.
- Reset mid-operation: assert rst during EXEC -> no done pulse, all outputs 0. Next req=3'b010 (ptr=0 after reset) -> requester 1 is served first.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the adder arbiter slice.
// The block time-shares one external 32-bit adder among several requesters.
package adder_arbiter_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_REQ = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Index width; a single-bit index is kept even for degenerate counts.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Scans req starting at ptr with wrap-around and reports the first hit.
module adder_arbiter_rr_pick
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    int j;

    // Walk offsets from high to low so the smallest offset wins last.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        j      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req[j]) begin
                any    = 1'b1;
                winner = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder among NUM_REQ requesters.
// One addition in flight: IDLE picks, EXEC lets the adder settle, RESP pulses done.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] op_a,
    input  logic [NUM_REQ*DATA_W-1:0] op_b,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         result,
    output logic                      ovf,
    output logic [DATA_W-1:0]         add_in1,
    output logic [DATA_W-1:0]         add_in2,
    input  logic [DATA_W-1:0]         add_out
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int MSB   = DATA_W - 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] gnt_d, done_d;
    logic [DATA_W-1:0]  result_d;
    logic               ovf_d;
    logic [DATA_W-1:0]  in1_d, in2_d;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;

    adder_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt     <= '0;
            done    <= '0;
            result  <= '0;
            ovf     <= 1'b0;
            add_in1 <= '0;
            add_in2 <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt     <= gnt_d;
            done    <= done_d;
            result  <= result_d;
            ovf     <= ovf_d;
            add_in1 <= in1_d;
            add_in2 <= in2_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = gnt;
        done_d   = done;
        result_d = result;
        ovf_d    = ovf;
        in1_d    = add_in1;
        in2_d    = add_in2;

        unique case (state_q)
            ST_IDLE: begin
                done_d = '0;
                gnt_d  = '0;
                if (pick_any) begin
                    in1_d   = op_a[int'(pick_idx)*DATA_W +: DATA_W];
                    in2_d   = op_b[int'(pick_idx)*DATA_W +: DATA_W];
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    win_d   = pick_idx;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = add_out;
                ovf_d    = (add_in1[MSB] == add_in2[MSB]) &&
                           (add_out[MSB] != add_in1[MSB]);
                done_d   = NUM_REQ'(1) << win_q;
                gnt_d    = '0;
                if (int'(win_q) == NUM_REQ - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = win_q + IDX_W'(1);
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                done_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                done_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter with a behavioural adder and random traffic.
// Expected service order comes from a circular scan of the request mask.
module tb_adder_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a, op_b;
    logic [N-1:0]   gnt, done;
    logic [W-1:0]   result, add_in1, add_in2, add_out;
    logic           ovf;

    adder_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .op_a    (op_a),
        .op_b    (op_b),
        .gnt     (gnt),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .add_in1 (add_in1),
        .add_in2 (add_in2),
        .add_out (add_out)
    );

    assign add_out = add_in1 + add_in2;

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic       ovf;
        bit         gap3;
    } exp_t;

    exp_t         q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           last_done = 0;
    int           mptr = 0;
    logic [W-1:0] va[N];
    logic [W-1:0] vb[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    // Reference: done carries the true sum and two's-complement overflow.
    function automatic exp_t make_exp(input int i, input bit gap);
        exp_t   e;
        longint s;
        e.idx  = i;
        e.a    = va[i];
        e.b    = vb[i];
        e.sum  = va[i] + vb[i];
        s      = longint'($signed(va[i])) + longint'($signed(vb[i]));
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.gap3 = gap;
        return e;
    endfunction

    // Monitor: gnt peeks the head entry, done pops it.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (gnt != '0 && done != '0) begin
                checks++;
                errors++;
                $display("FAIL gnt_done_overlap: gnt=%b done=%b", gnt, done);
            end
            if (gnt != '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_gnt", W'(gnt), '0);
                end else begin
                    chk("gnt_onehot", W'(gnt), W'(onehot(q[0].idx)));
                    chk("add_in1", add_in1, q[0].a);
                    chk("add_in2", add_in2, q[0].b);
                end
            end
            if (done != '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", W'(done), '0);
                end else begin
                    e = q.pop_front();
                    chk("done", W'(done), W'(onehot(e.idx)));
                    chk("result", result, e.sum);
                    chk("ovf", W'(ovf), W'(e.ovf));
                    if (e.gap3) chk("done_gap", W'(cyc - last_done), W'(3));
                end
                last_done = cyc;
            end
        end
    end

    task automatic run_batch(input logic [N-1:0] m, input bit chg,
                             input bit drop);
        logic [N-1:0] pend;
        int first;
        int k;
        int i;
        int budget;
        first = -1;
        k     = 0;
        for (int o = 0; o < N; o++) begin
            i = (mptr + o) % N;
            if (m[i]) begin
                q.push_back(make_exp(i, k > 0));
                if (first < 0) first = i;
                k++;
            end
        end
        for (int o = 0; o < N; o++) begin
            i = (mptr + o) % N;
            if (m[i]) k = i;
        end
        mptr = (k + 1) % N;
        for (int r = 0; r < N; r++) begin
            op_a[r*W +: W] = va[r];
            op_b[r*W +: W] = vb[r];
        end
        req  = m;
        pend = m;
        @(posedge clk); #2;
        chk("gnt_latency", W'(gnt), W'(onehot(first)));
        budget = 0;
        while (pend != '0 && budget < 4 * N + 4) begin
            for (int r = 0; r < N; r++) begin
                if (done[r]) begin
                    req[r]  = 1'b0;
                    pend[r] = 1'b0;
                end
                if (gnt[r]) begin
                    if (chg) begin
                        op_a[r*W +: W] = $urandom;
                        op_b[r*W +: W] = $urandom;
                    end
                    if (drop) req[r] = 1'b0;
                end
            end
            if (pend != '0) begin
                @(posedge clk); #2;
                budget++;
            end
        end
        if (pend != '0) begin
            checks++;
            errors++;
            $display("FAIL batch_timeout: pending=%b", pend);
            req = '0;
            q.delete();
        end
        @(posedge clk); #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gnt"}, W'(gnt), '0);
        chk({tag, "_done"}, W'(done), '0);
        chk({tag, "_result"}, result, '0);
        chk({tag, "_ovf"}, W'(ovf), '0);
        chk({tag, "_add_in1"}, add_in1, '0);
        chk({tag, "_add_in2"}, add_in2, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        req  = '0;
        op_a = '0;
        op_b = '0;
        for (int r = 0; r < N; r++) begin
            va[r] = '0;
            vb[r] = '0;
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        check_idle_outputs("reset");

        va[0] = 32'd5;
        vb[0] = 32'd12;
        run_batch(3'b001, 1'b0, 1'b0);

        for (int r = 0; r < N; r++) begin
            va[r] = $urandom;
            vb[r] = $urandom;
        end
        run_batch(3'b111, 1'b0, 1'b0);
        run_batch(3'b111, 1'b0, 1'b0);

        va[2] = 32'h7FFFFFFF;
        vb[2] = 32'h1;
        run_batch(3'b100, 1'b0, 1'b0);

        va[1] = 32'hFFFFFFFF;
        vb[1] = 32'h1;
        run_batch(3'b010, 1'b0, 1'b0);

        va[0] = 32'd5;
        vb[0] = 32'd12;
        run_batch(3'b001, 1'b1, 1'b1);

        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < N; r++) begin
                va[r] = rnd_val();
                vb[r] = rnd_val();
            end
            run_batch(N'($urandom_range(1, (1 << N) - 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abandon an operation by resetting in EXEC.
        va[2] = 32'd40;
        vb[2] = 32'd2;
        q.push_back(make_exp(2, 1'b0));
        op_a[2*W +: W] = va[2];
        op_b[2*W +: W] = vb[2];
        req = 3'b100;
        @(posedge clk); #2;
        chk("abort_gnt", W'(gnt), W'(3'b100));
        rst = 1'b1;
        req = '0;
        @(posedge clk); #2;
        rst = 1'b0;
        q.delete();
        mptr = 0;
        check_idle_outputs("abort");
        @(posedge clk); #2;
        chk("abort_no_done", W'(done), '0);

        va[0] = 32'd1;
        vb[0] = 32'd2;
        va[1] = 32'd30;
        vb[1] = 32'd4;
        run_batch(3'b011, 1'b0, 1'b0);
        run_batch(3'b010, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #2;
        chk("queue_empty", W'(q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
